// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, unsigned or two's-complement per operation.
// Iteration stops at the multiplier's top set bit; a zero operand finishes at once.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 sgn,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   mcand, acc, acc_sum;
    logic [WIDTH-1:0]     mplier, mplier_shr, a_mag, b_mag;
    logic                 neg, accept, zero_op;

    // Magnitudes: the most negative value maps to 2^(WIDTH-1), which fits unsigned.
    assign a_mag      = (sgn && a_in[WIDTH-1]) ? -a_in : a_in;
    assign b_mag      = (sgn && b_in[WIDTH-1]) ? -b_in : b_in;
    assign accept     = start && (state == IDLE || state == DONE);
    assign zero_op    = (a_mag == '0) || (b_mag == '0);
    assign mplier_shr = mplier >> 1;
    assign acc_sum    = acc + (mplier[0] ? mcand : '0);

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = zero_op ? DONE : CALC;
                else
                    state_next = IDLE;
            end
            CALC:    if (mplier_shr == '0) state_next = FIX;
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an aborted operation leaves
    // no residue and product reads zero immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        neg    <= sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        if (zero_op)
                            product <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mplier <= mplier_shr;
                    mcand  <= mcand << 1;
                end
                FIX: begin
                    product <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): driver pushes expected product,
// done cycle and busy length; a negedge monitor pops and compares on each done.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_in, b_in;
    logic        sgn;
    logic [15:0] product;
    logic        busy, done;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .sgn     (sgn),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", {16'd0, product}, {16'd0, e.prod});
                    check("done_cycle", cyc, e.cyc);
                    check("busy_len", busy_cnt, e.busy_len);
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; k = bit length of |b|, 0 for a zero-operand operation.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] p, input int k);
        exp_t e;
        e.prod     = p;
        e.cyc      = (k == 0) ? cyc + 1 : cyc + k + 2;
        e.busy_len = (k == 0) ? 0 : k + 1;
        sb.push_back(e);
        a_in  = a;
        b_in  = b;
        sgn   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (40) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        sgn   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned
        issue(8'd13, 8'd11, 1'b0, 16'h008F, 4);
        wait_idle();
        issue(8'd255, 8'd255, 1'b0, 16'hFE01, 8);
        wait_idle();
        issue(8'd1, 8'd1, 1'b0, 16'h0001, 1);
        wait_idle();

        // Signed
        issue(8'hFD, 8'd5, 1'b1, 16'hFFF1, 3);
        wait_idle();
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 8);
        wait_idle();
        issue(8'd127, 8'hFF, 1'b1, 16'hFF81, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("idle_hold", {16'd0, product}, 32'h0000FF81);

        // Zero early exit
        issue(8'd0, 8'd200, 1'b0, 16'h0000, 0);
        wait_idle();
        issue(8'd77, 8'd0, 1'b0, 16'h0000, 0);
        wait_idle();

        // start pulsed mid-CALC must be ignored
        issue(8'd13, 8'd11, 1'b0, 16'h008F, 4);
        a_in  = 8'd2;
        b_in  = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Back-to-back through DONE
        issue(8'd10, 8'd20, 1'b0, 16'h00C8, 5);
        wait_done();
        issue(8'hFE, 8'd3, 1'b1, 16'hFFFA, 2);
        wait_idle();

        // Reset mid-CALC of 200x3: outputs clear at once, no done pulse follows
        a_in  = 8'd200;
        b_in  = 8'd3;
        sgn   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("calc_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);

        issue(8'd6, 8'd7, 1'b0, 16'h002A, 3);
        wait_idle();

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
